// File: rtl/lightbike_pkg.sv
// Shared lightbike geometry: frame-buffer dimensions, sprite box bounds,
// orientation codes and the frame-address type used by writer and hit test.
package lightbike_pkg;

  localparam int H_RES     = 640;
  localparam int FB_DEPTH  = 307200;
  localparam int BOX       = 30;
  localparam int NARROW_LO = 7;
  localparam int NARROW_HI = 23;
  localparam int LB_DATA_W = 8;
  localparam int FB_ADDR_W = 19;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [4:0]           coord_t;
  typedef logic [2:0]           orient_t;

  localparam orient_t ORIENT_UP    = 3'd0;
  localparam orient_t ORIENT_LEFT  = 3'd1;
  localparam orient_t ORIENT_DOWN  = 3'd2;
  localparam orient_t ORIENT_RIGHT = 3'd3;
  localparam orient_t ORIENT_FULL  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } wr_state_t;

  // Vertical travel squeezes the sprite in x; horizontal travel squeezes it in y.
  function automatic logic narrow_x(input orient_t o);
    return (o == ORIENT_UP) || (o == ORIENT_DOWN);
  endfunction

  function automatic logic narrow_y(input orient_t o);
    return (o == ORIENT_LEFT) || (o == ORIENT_RIGHT);
  endfunction

endpackage

// File: rtl/sprite_box_writer_if.sv
// Frame-buffer write port: one address/colour beat under valid/ready.
interface sprite_box_writer_if
  import lightbike_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  fb_addr_t          wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/sprite_bounds.sv
// Orientation to exclusive box bounds; a pixel is interior when
// xlo < x < xhi and ylo < y < yhi.
module sprite_bounds
  import lightbike_pkg::*;
(
  input  orient_t orient,
  output coord_t  xlo,
  output coord_t  xhi,
  output coord_t  ylo,
  output coord_t  yhi
);

  always_comb begin
    xlo = '0;
    xhi = coord_t'(BOX);
    ylo = '0;
    yhi = coord_t'(BOX);
    if (narrow_x(orient)) begin
      xlo = coord_t'(NARROW_LO);
      xhi = coord_t'(NARROW_HI);
    end
    if (narrow_y(orient)) begin
      ylo = coord_t'(NARROW_LO);
      yhi = coord_t'(NARROW_HI);
    end
  end

endmodule

// File: rtl/sprite_box_writer.sv
// Rasterises one bike sprite footprint into the frame buffer, one
// address/colour beat per interior pixel, clipping addresses past the frame.
module sprite_box_writer
  import lightbike_pkg::*;
#(
  parameter int DATA_W = LB_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  fb_addr_t                   startaddr,
  input  orient_t                    orient,
  input  logic [DATA_W-1:0]          color,
  sprite_box_writer_if.master        wr,
  output logic                       busy,
  output logic                       done
);

  // One extra bit so an address that wraps past 2^19 still reads as out of frame.
  typedef logic [FB_ADDR_W:0] addr_ext_t;
  localparam addr_ext_t FB_DEPTH_EXT = addr_ext_t'(FB_DEPTH);

  wr_state_t         r_state;
  fb_addr_t          r_start;
  orient_t           r_orient;
  logic [DATA_W-1:0] r_data;
  coord_t            r_x;
  coord_t            r_y;
  addr_ext_t         r_addr;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  coord_t    w_xlo;
  coord_t    w_xhi;
  coord_t    w_ylo;
  coord_t    w_yhi;
  coord_t    w_xfirst;
  coord_t    w_yfirst;
  addr_ext_t w_row_off;
  addr_ext_t w_first_addr;
  addr_ext_t w_row_step;
  addr_ext_t w_next_addr;
  logic      w_row_end;
  logic      w_last;
  logic      w_advance;

  sprite_bounds u_bounds (
    .orient (r_orient),
    .xlo    (w_xlo),
    .xhi    (w_xhi),
    .ylo    (w_ylo),
    .yhi    (w_yhi)
  );

  assign w_xfirst = w_xlo + 5'd1;
  assign w_yfirst = w_ylo + 5'd1;

  // yfirst * 640 as 512 + 128 shifts; the row pitch is fixed by the frame format.
  assign w_row_off    = (addr_ext_t'(w_yfirst) << 9) + (addr_ext_t'(w_yfirst) << 7);
  assign w_first_addr = addr_ext_t'(r_start) + w_row_off + addr_ext_t'(w_xfirst);

  // Jump from the last interior column of one row to the first of the next.
  assign w_row_step  = addr_ext_t'(H_RES + 2) - addr_ext_t'(w_xhi - w_xlo);

  assign w_row_end   = (r_x == w_xhi - 5'd1);
  assign w_last      = w_row_end && (r_y == w_yhi - 5'd1);
  assign w_next_addr = w_row_end ? (r_addr + w_row_step) : (r_addr + addr_ext_t'(1));
  assign w_advance   = !r_valid || wr.wr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_start  <= '0;
      r_orient <= '0;
      r_data   <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_addr   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_start  <= startaddr;
            r_orient <= orient;
            r_data   <= color;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_x     <= w_xfirst;
          r_y     <= w_yfirst;
          r_addr  <= w_first_addr;
          r_valid <= (w_first_addr < FB_DEPTH_EXT);
          r_state <= S_WRITE;
        end

        S_WRITE: begin
          // Clipped pixels have r_valid low, so they step through without a handshake.
          if (w_advance) begin
            if (w_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_x     <= w_row_end ? w_xfirst : (r_x + 5'd1);
              r_y     <= w_row_end ? (r_y + 5'd1) : r_y;
              r_addr  <= w_next_addr;
              r_valid <= (w_next_addr < FB_DEPTH_EXT);
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wr.wr_valid = r_valid;
  assign wr.wr_addr  = r_addr[FB_ADDR_W-1:0];
  assign wr.wr_data  = r_data;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_sprite_box_writer.sv
// Self-checking bench for sprite_box_writer: directed plan cases plus random
// boxes against a per-pixel raster model of the sprite footprint.
module tb_sprite_box_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [18:0] startaddr;
  logic [2:0]  orient;
  logic [7:0]  color;
  logic        busy;
  logic        done;

  sprite_box_writer_if #(.DATA_W(8)) bus ();

  sprite_box_writer #(.DATA_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .startaddr (startaddr),
    .orient    (orient),
    .color     (color),
    .wr        (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int got_q[$];
  int exp_total;
  int exp_first_k;

  // Reference raster: walk every pixel of the 30x30 box in x-fastest order.
  function automatic void build_expect(input int sa, input int ori);
    bit vert;
    bit horz;
    bit inx;
    bit iny;
    int a;
    vert = (ori == 0) || (ori == 2);
    horz = (ori == 1) || (ori == 3);
    exp_q.delete();
    exp_total   = 0;
    exp_first_k = -1;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 30; x++) begin
        inx = vert ? (x > 7 && x < 23) : (x > 0 && x < 30);
        iny = horz ? (y > 7 && y < 23) : (y > 0 && y < 30);
        if (inx && iny) begin
          a = sa + y * 640 + x;
          if (a < 307200) begin
            if (exp_first_k < 0) exp_first_k = 2 + exp_total;
            exp_q.push_back(a);
          end
          exp_total++;
        end
      end
    end
  endfunction

  // rmode: 0 ready always high, 1 random ready, 2 three-cycle stall on beat 5.
  task automatic run_box(input int sa, input int ori, input int col, input int rmode,
                         input bit poke, input string tag);
    int k, beats, stalls, stall_left;
    bit got_done, prev_stall, seen_first;
    logic [18:0] prev_addr;
    logic [7:0]  prev_data;
    build_expect(sa, ori);
    got_q.delete();
    @(negedge clock);
    start = 1'b1; startaddr = 19'(sa); orient = 3'(ori); color = 8'(col);
    bus.wr_ready = 1'b1;
    k = 0; beats = 0; stalls = 0; stall_left = 3;
    got_done = 0; prev_stall = 0; seen_first = 0;
    prev_addr = '0; prev_data = '0;
    while (!got_done && k < 5000) begin
      @(negedge clock);
      k++;
      start = 1'b0;
      startaddr = 19'($urandom); orient = 3'($urandom); color = 8'($urandom);
      if (poke && k == 50) start = 1'b1;
      if (k == 1) begin
        n_vec++;
        if (bus.wr_valid !== 1'b0 || busy !== 1'b1)
          $display("FAIL %s load_cycle: valid=%b busy=%b, required valid=0 busy=1", tag, bus.wr_valid, busy);
        if (bus.wr_valid !== 1'b0 || busy !== 1'b1) n_err++;
      end
      if (prev_stall) begin
        n_vec++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== prev_addr || bus.wr_data !== prev_data) begin
          n_err++;
          $display("FAIL %s hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                   tag, bus.wr_valid, bus.wr_addr, bus.wr_data, prev_addr, prev_data);
        end
      end
      case (rmode)
        0: bus.wr_ready = 1'b1;
        1: bus.wr_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.wr_ready = 1'b1;
          if (bus.wr_valid === 1'b1 && beats == 5 && stall_left > 0) begin
            bus.wr_ready = 1'b0;
            stall_left--;
          end
        end
      endcase
      if (done === 1'b1) begin
        got_done = 1;
        n_vec++;
        if (k != 2 + exp_total + stalls || busy !== 1'b0) begin
          n_err++;
          $display("FAIL %s done_timing: cycle=%0d busy=%b, required cycle=%0d busy=0",
                   tag, k, busy, 2 + exp_total + stalls);
        end
        n_vec++;
        if (beats != exp_q.size()) begin
          n_err++;
          $display("FAIL %s beat_count: got %0d, required %0d", tag, beats, exp_q.size());
        end
        prev_stall = 0;
      end else begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy: got %b at cycle %0d, required 1", tag, busy, k);
        end
        if (bus.wr_valid === 1'b1) begin
          if (!seen_first) begin
            seen_first = 1;
            n_vec++;
            if (k != exp_first_k) begin
              n_err++;
              $display("FAIL %s first_beat_cycle: got %0d, required %0d", tag, k, exp_first_k);
            end
          end
          n_vec++;
          if (bus.wr_data !== 8'(col)) begin
            n_err++;
            $display("FAIL %s data: got %h, required %h", tag, bus.wr_data, 8'(col));
          end
          if (bus.wr_ready) begin
            n_vec++;
            if (beats >= exp_q.size()) begin
              n_err++;
              $display("FAIL %s overrun: extra beat addr=%0d, required only %0d beats", tag, bus.wr_addr, exp_q.size());
            end else if (int'(bus.wr_addr) != exp_q[beats]) begin
              n_err++;
              $display("FAIL %s addr[%0d]: got %0d, required %0d", tag, beats, bus.wr_addr, exp_q[beats]);
            end
            got_q.push_back(int'(bus.wr_addr));
            beats++;
            prev_stall = 0;
          end else begin
            stalls++;
            prev_stall = 1;
            prev_addr = bus.wr_addr;
            prev_data = bus.wr_data;
          end
        end else begin
          prev_stall = 0;
        end
      end
    end
    if (!got_done) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: no done after %0d cycles, required done", tag, k);
    end
    if (poke) begin
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clock);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || bus.wr_valid !== 1'b0) begin
          n_err++;
          $display("FAIL %s start_in_done: busy=%b valid=%b, required busy=0 valid=0", tag, busy, bus.wr_valid);
        end
      end
    end
    $display("box %s: sa=%0d orient=%0d beats=%0d stalls=%0d cycles=%0d", tag, sa, ori, beats, stalls, k);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; startaddr = '0; orient = '0; color = 8'hFF;
    bus.wr_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (bus.wr_valid !== 1'b0 || bus.wr_addr !== 19'd0 || bus.wr_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b addr=%0d data=%h busy=%b done=%b, required all 0",
               bus.wr_valid, bus.wr_addr, bus.wr_data, busy, done);
    end
    start = 1'b0;
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_orient_up;
    run_box(0, 0, 8'h5A, 0, 0, "up");
    n_vec++;
    if (got_q.size() != 435 || got_q[0] != 648 || got_q[got_q.size()-1] != 18582) begin
      n_err++;
      $display("FAIL up_stream: size=%0d first=%0d last=%0d, required 435/648/18582",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : -1, (got_q.size() > 0) ? got_q[got_q.size()-1] : -1);
    end
  endtask

  task automatic test_orient_left;
    run_box(1000, 1, 8'hC3, 0, 0, "left");
    n_vec++;
    if (got_q.size() != 435 || got_q[0] != 6121 || got_q[1] != 6122 || got_q[29] != 6761 ||
        got_q[got_q.size()-1] != 15109) begin
      n_err++;
      $display("FAIL left_stream: size=%0d, required 435 beats with 6121,6122,row2=6761,last=15109", got_q.size());
    end
  endtask

  task automatic test_full;
    int saved[$];
    int diffs;
    run_box(0, 5, 8'h11, 0, 0, "full5");
    n_vec++;
    if (got_q.size() != 841 || got_q[0] != 641 || got_q[got_q.size()-1] != 18589) begin
      n_err++;
      $display("FAIL full5_stream: size=%0d, required 841 beats 641..18589", got_q.size());
    end
    saved = got_q;
    run_box(0, 6, 8'h11, 0, 0, "full6");
    diffs = (got_q.size() != saved.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < saved.size(); i++)
      if (got_q[i] != saved[i]) diffs++;
    n_vec++;
    if (diffs != 0) begin
      n_err++;
      $display("FAIL orient6_vs_5: %0d differing beats, required 0", diffs);
    end
  endtask

  task automatic test_clipped;
    int max_a;
    run_box(300800, 5, 8'h77, 0, 0, "clip");
    max_a = 0;
    foreach (got_q[i]) if (got_q[i] > max_a) max_a = got_q[i];
    n_vec++;
    if (got_q.size() != 261 || max_a != 306589) begin
      n_err++;
      $display("FAIL clip_stream: size=%0d max=%0d, required 261 beats max 306589", got_q.size(), max_a);
    end
    run_box(400000, 0, 8'h33, 0, 0, "allclip");
    n_vec++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL allclip_stream: size=%0d, required 0", got_q.size());
    end
  endtask

  task automatic test_stall;
    run_box(5000, 3, 8'h9C, 2, 0, "stall");
  endtask

  task automatic test_reset_abort;
    int beats;
    bit saw_valid, saw_done;
    @(negedge clock);
    start = 1'b1; startaddr = '0; orient = 3'd0; color = 8'h42; bus.wr_ready = 1'b1;
    beats = 0;
    for (int k = 0; k < 600 && beats < 100; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (bus.wr_valid === 1'b1) beats++;
    end
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (bus.wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beats != 100) begin
      n_err++;
      $display("FAIL abort_state: beats=%0d valid=%b busy=%b done=%b, required 100/0/0/0", beats, bus.wr_valid, busy, done);
    end
    reset = 1'b0;
    saw_valid = 0; saw_done = 0;
    repeat (600) begin
      @(negedge clock);
      if (bus.wr_valid === 1'b1) saw_valid = 1;
      if (done === 1'b1) saw_done = 1;
    end
    n_vec++;
    if (saw_valid || saw_done) begin
      n_err++;
      $display("FAIL abort_quiet: valid_seen=%b done_seen=%b, required 0/0", saw_valid, saw_done);
    end
    $display("reset abort: beats before reset=%0d", beats);
  endtask

  task automatic test_start_ignored;
    run_box(2000, 2, 8'hE1, 0, 1, "poke");
  endtask

  task automatic test_back_to_back;
    run_box(12345, 1, 8'h01, 0, 0, "b2b_a");
    run_box(54321, 5, 8'h02, 1, 0, "b2b_b");
  endtask

  task automatic test_random;
    int sa, ori, sel;
    for (int n = 0; n < 8; n++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0)      sa = $urandom_range(0, 300000);
      else if (sel == 1) sa = $urandom_range(295000, 307199);
      else               sa = $urandom_range(500000, 524287);
      ori = $urandom_range(0, 7);
      run_box(sa, ori, $urandom_range(0, 255), 1, 0, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_orient_up;
    test_orient_left;
    test_full;
    test_clipped;
    test_stall;
    test_reset_abort;
    test_start_ignored;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
